perf_counter_bank: RTL and testbench

- Synthesizable, parametrised performance-event counter bank for the pipelined processor with caches.
- Counts a free-running cycle count plus NUM_CH per-cycle event strobes, for example inst-retire, icache req/hit and dcache req/hit.
- On halt it freezes all counts, then serially dumps them over a valid/ready stream.
- Sits beside the core under proc_hier; replaces bench-only counting so the counts also exist in silicon.

---
 rtl/perf_pkg.sv | 24 ++
 rtl/perf_counter_bank_if.sv | 17 +
 rtl/perf_sat_counter.sv | 44 ++++
 rtl/perf_counter_bank.sv | 121 ++++++++++++
 tb/tb_perf_counter_bank.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared types and helpers for the performance counter bank.
//   perfState_t  RUN / DUMP / DONE bank state
//   CYC_IDX      read/dump index of the free-running cycle counter
//   idxWidth()   width of an index covering the cycle counter plus numCh channels
//   maxWidth()   wider of two counter widths (read/dump bus width)
package perf_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } perfState_t;

  localparam int unsigned CYC_IDX = 0;

  function automatic int unsigned idxWidth(input int unsigned numCh);
    return (numCh < 1) ? 1 : $clog2(numCh + 1);
  endfunction

  function automatic int unsigned maxWidth(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: valid/ready stream carrying the frozen counter dump.
//   dump_valid  word available (master -> slave)
//   dump_ready  consumer accepts word (slave -> master)
//   dump_idx    index of the word: 0 = cycle counter, i = channel i-1
//   dump_data   zero-extended counter value
interface perf_counter_bank_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
  modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: one W-bit event counter with a sticky overflow flag.
//   clk, rst  clock, synchronous active-high reset
//   inc       count this cycle
//   clr       zero count and flag (beats hold and inc)
//   hold      freeze the count
//   count     current value
//   ovf       sticky flag
// Build option PERF_OVF_WRAP_EN: when defined the counter wraps and ovf marks
// the wrap; otherwise it saturates at all-ones and ovf marks reaching all-ones.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ONE      = W'(1);

  logic atMax;
  assign atMax = (count == ALL_ONES);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (!hold && inc) begin
`ifdef PERF_OVF_WRAP_EN
      count <= count + ONE;
      if (atMax) ovf <= 1'b1;
`else
      if (!atMax) count <= count + ONE;
      // flag goes up in the same cycle the count lands on all-ones
      if (count == ALL_ONES - ONE) ovf <= 1'b1;
`endif
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: free-running cycle counter plus NUM_CH event counters.
// Counts while RUN; halt freezes the counts and streams them out serially
// (index 0 = cycle counter, then channels), then parks in DONE until clear.
//   clk, rst    clock, synchronous active-high reset
//   event_in    per-cycle event strobes, bit i -> channel i
//   halt        freeze and dump (beats clear in RUN)
//   clear       zero counters (RUN), or zero and restart (DONE)
//   rd_sel      live read select, out-of-range reads 0
//   rd_data     registered live read value
//   dumpIf      dump stream (master)
//   dump_done   level while DONE
//   frozen      high in DUMP or DONE
//   ovf_flags   sticky overflow flags, bit 0 = cycle counter
// Build option PERF_OVF_WRAP_EN selects wrap vs saturate in perf_sat_counter.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CH = 5,
  parameter  int CNT_W  = 32,
  parameter  int CYC_W  = 32,
  localparam int IDX_W  = idxWidth(NUM_CH),
  localparam int DW     = maxWidth(CNT_W, CYC_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   event_in,
  input  logic                halt,
  input  logic                clear,
  input  logic [IDX_W-1:0]    rd_sel,
  output logic [DW-1:0]       rd_data,
  perf_counter_bank_if.master dumpIf,
  output logic                dump_done,
  output logic                frozen,
  output logic [NUM_CH:0]     ovf_flags
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

  perfState_t                     state, stateNxt;
  logic [IDX_W-1:0]               dumpIdx, dumpIdxNxt;
  logic                           cntClr, cntHold, fire;
  logic [CYC_W-1:0]               cycCount;
  logic [NUM_CH-1:0][CNT_W-1:0]   chCount;
  logic [NUM_CH:0][DW-1:0]        cntExt;

  assign fire = dumpIf.dump_valid && dumpIf.dump_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      dumpIdx <= '0;
    end else begin
      state   <= stateNxt;
      dumpIdx <= dumpIdxNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    dumpIdxNxt = dumpIdx;
    cntClr     = 1'b0;
    case (state)
      RUN: begin
        // the halt cycle itself still counts, so clear only acts without halt
        if (halt) begin
          stateNxt   = DUMP;
          dumpIdxNxt = '0;
        end else if (clear) begin
          cntClr = 1'b1;
        end
      end
      DUMP: begin
        if (fire) begin
          if (dumpIdx == LAST_IDX) begin
            stateNxt   = DONE;
            dumpIdxNxt = '0;
          end else begin
            dumpIdxNxt = dumpIdx + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (clear) begin
          cntClr   = 1'b1;
          stateNxt = RUN;
        end
      end
      default: stateNxt = RUN;
    endcase
  end

  assign cntHold = (state != RUN);

  perf_sat_counter #(.W(CYC_W)) uCyc (
    .clk(clk), .rst(rst), .inc(1'b1), .clr(cntClr), .hold(cntHold),
    .count(cycCount), .ovf(ovf_flags[CYC_IDX])
  );

  perf_sat_counter #(.W(CNT_W)) uCh [NUM_CH-1:0] (
    .clk(clk), .rst(rst), .inc(event_in), .clr(cntClr), .hold(cntHold),
    .count(chCount), .ovf(ovf_flags[NUM_CH:1])
  );

  assign cntExt[CYC_IDX] = DW'(cycCount);
  for (genvar i = 0; i < NUM_CH; i++) begin : gExt
    assign cntExt[i+1] = DW'(chCount[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)                    rd_data <= '0;
    else if (rd_sel <= LAST_IDX) rd_data <= cntExt[rd_sel];
    else                        rd_data <= '0;
  end

  assign dumpIf.dump_valid = (state == DUMP);
  assign dumpIf.dump_idx   = dumpIdx;
  assign dumpIf.dump_data  = (state == DUMP) ? cntExt[dumpIdx] : '0;
  assign dump_done         = (state == DONE);
  assign frozen            = (state != RUN);

endmodule

// File: tb/tb_perf_counter_bank.sv
`timescale 1ns/1ps
module tb_perf_counter_bank;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 4;
  localparam int CYC_W  = 32;
  localparam int IDX_W  = 3;
  localparam int DW     = 32;
  localparam longint CH_MAX  = (64'd1 << CNT_W) - 1;
  localparam longint CYC_MAX = (64'd1 << CYC_W) - 1;

  logic              clk = 1'b0;
  logic              rst, halt, clear;
  logic [NUM_CH-1:0] event_in;
  logic [IDX_W-1:0]  rd_sel;
  logic [DW-1:0]     rd_data;
  logic              dump_done, frozen;
  logic [NUM_CH:0]   ovf_flags;

  perf_counter_bank_if #(.IDX_W(IDX_W), .DATA_W(DW)) dIf ();

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .halt(halt), .clear(clear),
    .rd_sel(rd_sel), .rd_data(rd_data), .dumpIf(dIf), .dump_done(dump_done),
    .frozen(frozen), .ovf_flags(ovf_flags)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct { int idx; longint data; } word_t;
  typedef struct { int idx; longint data; int cyc; } obs_t;
  word_t expQ[$];
  obs_t  obsQ[$];

  longint          mCyc;
  longint          mCh[NUM_CH];
  logic [NUM_CH:0] mOvf;
  logic [3:0]      bpPat = 4'b1001;   // ready per cycle from idx1 on: 1,0,0,1
  int              bpFire[6] = '{0, 1, 4, 5, 8, 9};

  function automatic longint bump(input longint v, input longint maxv, output bit hit);
    hit = 1'b0;
`ifdef PERF_OVF_WRAP_EN
    if (v == maxv) begin hit = 1'b1; return 0; end
    return v + 1;
`else
    if (v != maxv) v = v + 1;
    if (v == maxv) hit = 1'b1;
    return v;
`endif
  endfunction

  function automatic void model_clear();
    mCyc = 0;
    for (int i = 0; i < NUM_CH; i++) mCh[i] = 0;
    mOvf = '0;
  endfunction

  // one RUN-state cycle: apply inputs, advance the model, push dump words on halt
  task automatic drive(input logic [NUM_CH-1:0] ev, input logic h, input logic c);
    bit hit;
    event_in = ev; halt = h; clear = c;
    if (c && !h) model_clear();
    else begin
      mCyc = bump(mCyc, CYC_MAX, hit);
      if (hit) mOvf[0] = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (ev[i]) begin
          mCh[i] = bump(mCh[i], CH_MAX, hit);
          if (hit) mOvf[i+1] = 1'b1;
        end
      if (h) begin
        expQ.push_back('{0, mCyc});
        for (int i = 0; i < NUM_CH; i++) expQ.push_back('{i + 1, mCh[i]});
      end
    end
    @(posedge clk); #1;
  endtask

  // consume the dump stream into obsQ; bp selects the backpressure pattern
  task automatic collect_dump(input bit bp, output bit to, output int stallErr);
    bit stalled = 1'b0;
    logic [IDX_W-1:0] hIdx = '0;
    logic [DW-1:0] hData = '0;
    logic r;
    halt = 0; clear = 0; event_in = '0;
    obsQ.delete(); to = 1'b1; stallErr = 0;
    for (int n = 0; n < 64; n++) begin
      if (dump_done) begin to = 1'b0; break; end
      r = (!bp || n == 0) ? 1'b1 : bpPat[(n-1) % 4];
      dIf.dump_ready = r;
      if (stalled && (dIf.dump_idx !== hIdx || dIf.dump_data !== hData)) stallErr++;
      if (dIf.dump_valid && r) begin
        obsQ.push_back('{int'(dIf.dump_idx), longint'(dIf.dump_data), n});
        stalled = 1'b0;
      end else begin
        stalled = dIf.dump_valid; hIdx = dIf.dump_idx; hData = dIf.dump_data;
      end
      @(posedge clk); #1;
    end
    dIf.dump_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1; halt = 0; clear = 0; event_in = '0; rd_sel = '0; dIf.dump_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear(); expQ.delete();
    nChecks++; if (rd_data !== '0) begin nFails++; $display("FAIL reset_rd_data got %0h want 0", rd_data); end
    nChecks++; if (dIf.dump_valid !== 1'b0) begin nFails++; $display("FAIL reset_dump_valid got %b want 0", dIf.dump_valid); end
    nChecks++; if (dIf.dump_idx !== '0) begin nFails++; $display("FAIL reset_dump_idx got %0d want 0", dIf.dump_idx); end
    nChecks++; if (dIf.dump_data !== '0) begin nFails++; $display("FAIL reset_dump_data got %0h want 0", dIf.dump_data); end
    nChecks++; if (dump_done !== 1'b0) begin nFails++; $display("FAIL reset_dump_done got %b want 0", dump_done); end
    nChecks++; if (frozen !== 1'b0) begin nFails++; $display("FAIL reset_frozen got %b want 0", frozen); end
    nChecks++; if (ovf_flags !== '0) begin nFails++; $display("FAIL reset_ovf got %b want 0", ovf_flags); end
    rst = 0;
  endtask

  task automatic test_dump_basic();
    bit to; int se; word_t e;
    rst = 1; @(posedge clk); #1; rst = 0;
    model_clear(); expQ.delete();
    repeat (10) drive(5'b00101, 0, 0);
    drive(5'b00101, 1, 0);
    nChecks++; if (frozen !== 1'b1) begin nFails++; $display("FAIL basic_frozen got %b want 1", frozen); end
    collect_dump(1'b0, to, se);
    nChecks++; if (to) begin nFails++; $display("FAIL basic_timeout dump_done never seen"); end
    nChecks++; if (obsQ.size() != NUM_CH + 1) begin nFails++; $display("FAIL basic_count got %0d words want %0d", obsQ.size(), NUM_CH + 1); end
    for (int k = 0; k < obsQ.size(); k++) begin
      if (expQ.size() == 0) begin nChecks++; nFails++; $display("FAIL basic_extra word %0d", k); continue; end
      e = expQ.pop_front();
      nChecks++; if (obsQ[k].idx != e.idx || obsQ[k].data != e.data) begin nFails++; $display("FAIL basic_word%0d got idx%0d=%0d want idx%0d=%0d", k, obsQ[k].idx, obsQ[k].data, e.idx, e.data); end
      nChecks++; if (obsQ[k].cyc != k) begin nFails++; $display("FAIL basic_cycle%0d got cycle %0d want %0d", k, obsQ[k].cyc, k); end
    end
    nChecks++; if (obsQ.size() > 0 && obsQ[0].data != 11) begin nFails++; $display("FAIL basic_cyc11 got %0d want 11", obsQ[0].data); end
    nChecks++; if (dump_done !== 1'b1 || dIf.dump_valid !== 1'b0) begin nFails++; $display("FAIL basic_done got done=%b valid=%b want 1/0", dump_done, dIf.dump_valid); end
  endtask

  task automatic test_backpressure();
    bit to; int se; word_t e;
    clear = 1; @(posedge clk); #1; clear = 0;
    model_clear(); expQ.delete();
    nChecks++; if (dump_done !== 1'b0 || frozen !== 1'b0) begin nFails++; $display("FAIL bp_restart got done=%b frozen=%b want 0/0", dump_done, frozen); end
    for (int i = 0; i < 7; i++) drive(NUM_CH'($urandom_range(0, 31)), 0, 0);
    drive(NUM_CH'($urandom_range(0, 31)), 1, 0);
    collect_dump(1'b1, to, se);
    nChecks++; if (to) begin nFails++; $display("FAIL bp_timeout dump_done never seen"); end
    nChecks++; if (se != 0) begin nFails++; $display("FAIL bp_stable got %0d changes during stall want 0", se); end
    nChecks++; if (obsQ.size() != NUM_CH + 1) begin nFails++; $display("FAIL bp_count got %0d words want %0d", obsQ.size(), NUM_CH + 1); end
    for (int k = 0; k < obsQ.size(); k++) begin
      if (expQ.size() == 0 || k > 5) begin nChecks++; nFails++; $display("FAIL bp_extra word %0d", k); continue; end
      e = expQ.pop_front();
      nChecks++; if (obsQ[k].idx != e.idx || obsQ[k].data != e.data) begin nFails++; $display("FAIL bp_word%0d got idx%0d=%0d want idx%0d=%0d", k, obsQ[k].idx, obsQ[k].data, e.idx, e.data); end
      nChecks++; if (obsQ[k].cyc != bpFire[k]) begin nFails++; $display("FAIL bp_cycle%0d got cycle %0d want %0d", k, obsQ[k].cyc, bpFire[k]); end
    end
  endtask

  task automatic test_halt_clear();
    bit to; int se; word_t e;
    clear = 1; @(posedge clk); #1; clear = 0;
    model_clear(); expQ.delete();
    repeat (4) drive(5'b11010, 0, 0);
    drive(5'b11111, 1, 1);
    nChecks++; if (frozen !== 1'b1 || dIf.dump_valid !== 1'b1) begin nFails++; $display("FAIL hc_dump_entered got frozen=%b valid=%b want 1/1", frozen, dIf.dump_valid); end
    collect_dump(1'b0, to, se);
    nChecks++; if (to || obsQ.size() != NUM_CH + 1) begin nFails++; $display("FAIL hc_count got %0d words timeout=%b want %0d", obsQ.size(), to, NUM_CH + 1); end
    for (int k = 0; k < obsQ.size(); k++) begin
      if (expQ.size() == 0) begin nChecks++; nFails++; $display("FAIL hc_extra word %0d", k); continue; end
      e = expQ.pop_front();
      nChecks++; if (obsQ[k].idx != e.idx || obsQ[k].data != e.data) begin nFails++; $display("FAIL hc_word%0d got idx%0d=%0d want idx%0d=%0d", k, obsQ[k].idx, obsQ[k].data, e.idx, e.data); end
    end
    nChecks++; if (obsQ.size() > 1 && (obsQ[0].data != 5 || obsQ[1].data != 1)) begin nFails++; $display("FAIL hc_counted got cyc=%0d ch0=%0d want 5/1", obsQ[0].data, obsQ[1].data); end
    // clear in DONE with halt also high: halt must be ignored
    halt = 1; clear = 1; @(posedge clk); #1; halt = 0; clear = 0;
    model_clear();
    nChecks++; if (dump_done !== 1'b0 || frozen !== 1'b0) begin nFails++; $display("FAIL hc_back_to_run got done=%b frozen=%b want 0/0", dump_done, frozen); end
    nChecks++; if (ovf_flags !== '0) begin nFails++; $display("FAIL hc_ovf got %b want 0", ovf_flags); end
    for (int k = 0; k <= NUM_CH; k++) begin
      rd_sel = IDX_W'(k);
      drive('0, 0, 0);
      nChecks++; if (rd_data !== '0) begin nFails++; $display("FAIL hc_zero_sel%0d got %0d want 0", k, rd_data); end
    end
  endtask

  task automatic test_saturation();
    bit expOvf;
    drive(5'b00001, 0, 1);
    nChecks++; if (ovf_flags !== '0) begin nFails++; $display("FAIL sat_clear_ovf got %b want 0", ovf_flags); end
    rd_sel = 3'd1;
    for (int n = 1; n <= 20; n++) begin
      drive(5'b00001, 0, 0);
`ifdef PERF_OVF_WRAP_EN
      expOvf = (n >= 16);
`else
      expOvf = (n >= 15);
`endif
      nChecks++; if (ovf_flags[1] !== expOvf) begin nFails++; $display("FAIL sat_ovf_n%0d got %b want %b", n, ovf_flags[1], expOvf); end
    end
    drive('0, 0, 0);
`ifdef PERF_OVF_WRAP_EN
    nChecks++; if (rd_data !== 32'd4) begin nFails++; $display("FAIL sat_value got %0d want 4", rd_data); end
`else
    nChecks++; if (rd_data !== 32'd15) begin nFails++; $display("FAIL sat_value got %0d want 15", rd_data); end
`endif
    nChecks++; if (ovf_flags !== mOvf) begin nFails++; $display("FAIL sat_flags got %b want %b", ovf_flags, mOvf); end
    // clear drops the same-cycle event and the sticky flags
    drive(5'b00001, 0, 1);
    drive('0, 0, 0);
    nChecks++; if (rd_data !== '0 || ovf_flags !== '0) begin nFails++; $display("FAIL sat_cleared got rd=%0d ovf=%b want 0/0", rd_data, ovf_flags); end
  endtask

  task automatic test_reset_mid_dump();
    bit to; int se; word_t e;
    repeat (3) drive(5'b00011, 0, 0);
    drive('0, 1, 0);
    dIf.dump_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (dIf.dump_idx !== 3'd2 || dIf.dump_valid !== 1'b1) begin nFails++; $display("FAIL rmd_at_idx2 got idx=%0d valid=%b want 2/1", dIf.dump_idx, dIf.dump_valid); end
    rst = 1; @(posedge clk); #1; rst = 0; dIf.dump_ready = 0;
    model_clear(); expQ.delete();
    nChecks++; if (frozen !== 1'b0 || dIf.dump_valid !== 1'b0 || dump_done !== 1'b0) begin nFails++; $display("FAIL rmd_run got frozen=%b valid=%b done=%b want 0/0/0", frozen, dIf.dump_valid, dump_done); end
    rd_sel = 3'd0;
    drive('0, 0, 0);
    nChecks++; if (rd_data !== '0) begin nFails++; $display("FAIL rmd_cyc_zero got %0d want 0", rd_data); end
    drive('0, 0, 0);
    drive('0, 1, 0);
    collect_dump(1'b0, to, se);
    nChecks++; if (to || obsQ.size() != NUM_CH + 1) begin nFails++; $display("FAIL rmd_count got %0d words timeout=%b want %0d", obsQ.size(), to, NUM_CH + 1); end
    for (int k = 0; k < obsQ.size(); k++) begin
      if (expQ.size() == 0) begin nChecks++; nFails++; $display("FAIL rmd_extra word %0d", k); continue; end
      e = expQ.pop_front();
      nChecks++; if (obsQ[k].idx != e.idx || obsQ[k].data != e.data) begin nFails++; $display("FAIL rmd_word%0d got idx%0d=%0d want idx%0d=%0d", k, obsQ[k].idx, obsQ[k].data, e.idx, e.data); end
    end
    nChecks++; if (obsQ.size() > 0 && obsQ[0].data != 3) begin nFails++; $display("FAIL rmd_cyc3 got %0d want 3", obsQ[0].data); end
  endtask

  task automatic test_live_read();
    longint expv[4] = '{0, 1, 2, 3};
    longint cycExp;
    clear = 1; @(posedge clk); #1; clear = 0;
    model_clear(); expQ.delete();
    rd_sel = 3'd1;
    for (int n = 0; n < 4; n++) begin
      drive((n < 3) ? 5'b00001 : 5'b00000, 0, 0);
      nChecks++; if (rd_data !== DW'(expv[n])) begin nFails++; $display("FAIL live_n%0d got %0d want %0d", n, rd_data, expv[n]); end
    end
    rd_sel = 3'd7;
    drive('0, 0, 0);
    nChecks++; if (rd_data !== '0) begin nFails++; $display("FAIL live_oor got %0d want 0", rd_data); end
    rd_sel = 3'd0;
    cycExp = mCyc;
    drive('0, 0, 0);
    nChecks++; if (rd_data !== DW'(cycExp)) begin nFails++; $display("FAIL live_cyc got %0d want %0d", rd_data, cycExp); end
  endtask

  initial begin
    test_reset();
    test_dump_basic();
    test_backpressure();
    test_halt_clear();
    test_saturation();
    test_reset_mid_dump();
    test_live_read();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
